// File: rtl/opc5ls_busctl_if.sv
// Bus bundle between the opc5ls bus controller and its CPU, SRAM and I/O page.
// master is the controller side; slave is the environment (CPU, SRAM, I/O device).
interface opc5ls_busctl_if;
  logic [15:0] address;
  logic [15:0] dout;
  logic        rnw;
  logic        vpa;
  logic        vda;
  logic [15:0] din;
  logic        clken;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ce_b;
  logic        mem_oe_b;
  logic        mem_we_b;
  logic        io_req;
  logic        io_rnw;
  logic [7:0]  io_addr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        io_ack;
  logic        bus_err;

  modport master (
    input  address, dout, rnw, vpa, vda, mem_rdata, io_rdata, io_ack,
    output din, clken, mem_addr, mem_wdata, mem_ce_b, mem_oe_b, mem_we_b,
           io_req, io_rnw, io_addr, io_wdata, bus_err
  );

  modport slave (
    output address, dout, rnw, vpa, vda, mem_rdata, io_rdata, io_ack,
    input  din, clken, mem_addr, mem_wdata, mem_ce_b, mem_oe_b, mem_we_b,
           io_req, io_rnw, io_addr, io_wdata, bus_err
  );
endinterface

// File: rtl/opc5ls_busctl.sv
// opc5ls bus controller: routes each CPU cycle to wait-stated SRAM or a req/ack I/O
// page with timeout, stalling the CPU through clken until the access completes.
module opc5ls_busctl #(
  parameter int unsigned MEM_WS     = 1,
  parameter logic [7:0]  IO_PAGE    = 8'hFE,
  parameter int unsigned IO_TIMEOUT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input logic             clk,
  input logic             reset_b,
  opc5ls_busctl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM    = 2'd1,
    IO_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MEM_WS_C = CNT_W'(MEM_WS);
  localparam logic [CNT_W-1:0] IO_TO_C  = CNT_W'(IO_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      din_q, din_nxt;
  logic             bus_err_q, bus_err_nxt;
  logic             req;
  logic             isio;
  logic             cnt_zero;

  assign req      = bus.vpa | bus.vda;
  assign isio     = req && (bus.address[15:8] == IO_PAGE);
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      cnt       <= '0;
      din_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      din_q     <= din_nxt;
      bus_err_q <= bus_err_nxt;
    end
  end

  // One counter serves both SRAM wait states and the I/O timeout; reaching zero always exits.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    din_nxt     = din_q;
    bus_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (isio) begin
            state_nxt = IO_REQ;
            cnt_nxt   = IO_TO_C;
          end else begin
            state_nxt = MEM;
            cnt_nxt   = MEM_WS_C;
          end
        end
      end
      MEM: begin
        if (cnt_zero) begin
          if (bus.rnw) din_nxt = bus.mem_rdata;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      IO_REQ: begin
        if (bus.io_ack) begin
          if (bus.rnw) din_nxt = bus.io_rdata;
          state_nxt = DONE;
        end else if (cnt_zero) begin
          if (bus.rnw) din_nxt = 16'hFFFF;
          bus_err_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // clken is forced high during reset so the CPU reset synchroniser can advance.
  always_comb begin
    bus.clken    = 1'b1;
    bus.mem_ce_b = 1'b1;
    bus.mem_oe_b = 1'b1;
    bus.mem_we_b = 1'b1;
    bus.io_req   = 1'b0;
    case (state)
      IDLE:   bus.clken = !req || !reset_b;
      MEM: begin
        bus.clken    = 1'b0;
        bus.mem_ce_b = 1'b0;
        bus.mem_oe_b = !bus.rnw;
        bus.mem_we_b = bus.rnw;
      end
      IO_REQ: begin
        bus.clken  = 1'b0;
        bus.io_req = 1'b1;
      end
      default: bus.clken = 1'b1;
    endcase
  end

  assign bus.din       = din_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.mem_addr  = bus.address;
  assign bus.mem_wdata = bus.dout;
  assign bus.io_rnw    = bus.rnw;
  assign bus.io_addr   = bus.address[7:0];
  assign bus.io_wdata  = bus.dout;

endmodule
